mult_div_unit: RTL and testbench

- Iterative multiply/divide unit for the HI/LO instructions: mult, multu, div, divu, mthi, mtlo, mfhi, mflo.
- Sits directly downstream of the GPR file. It consumes busA (Rs) and busB (Rt) as operands.
- hi/lo feed the writeback mux that drives busW for mfhi/mflo.
- The controller stalls the pipeline while busy=1.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_step.sv | 42 ++++
 rtl/mult_div_unit.sv | 166 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared encodings and constants for the HI/LO multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam int MDU_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_step
// Description : One combinational iteration: MSB-first shift-add multiply or
//               restoring divide producing one quotient bit.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic               bit_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic [1:0]         op_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               q_o
);

    logic               w_is_div;
    logic [2*WIDTH-1:0] w_mul;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;

    always_comb begin
        w_is_div = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
        w_mul    = (acc_i << 1) + (bit_i ? {{WIDTH{1'b0}}, opnd_i} : '0);
        // Divide keeps a WIDTH+1 bit partial remainder in the low bits of acc.
        w_shift  = {acc_i[WIDTH-1:0], bit_i};
        w_diff   = {1'b0, w_shift} - {2'b00, opnd_i};
        if (w_is_div) begin
            q_o   = ~w_diff[WIDTH+1];
            acc_o = {{(WIDTH-1){1'b0}}, (q_o ? w_diff[WIDTH:0] : w_shift)};
        end else begin
            q_o   = 1'b0;
            acc_o = w_mul;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative 33-cycle multiply/divide unit with HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_res_q, neg_res_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               w_sa, w_sb;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_rem, w_quot;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc_i  (acc_q),
        .bit_i  (shreg_q[WIDTH-1]),
        .opnd_i (opnd_q),
        .op_i   (op_q),
        .acc_o  (w_acc_nxt),
        .q_o    (w_qbit)
    );

    always_comb begin
        w_sa    = ~op[0] & busA[WIDTH-1];
        w_sb    = ~op[0] & busB[WIDTH-1];
        w_mag_a = w_sa ? -busA : busA;
        w_mag_b = w_sb ? -busB : busB;

        w_prod  = neg_res_q ? -acc_q : acc_q;
        w_rem   = neg_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        // A zero divisor yields an all-ones quotient; the remainder path already
        // reconstructs the original dividend, so only the quotient sign is skipped.
        if (opnd_q == '0)
            w_quot = '1;
        else
            w_quot = neg_res_q ? -shreg_q : shreg_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_a_d   = neg_a_q;
        neg_res_d = neg_res_q;
        opnd_d    = opnd_q;
        shreg_d   = shreg_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = op;
                    neg_a_d   = w_sa;
                    neg_res_d = w_sa ^ w_sb;
                    // The shift register holds the operand consumed bit by bit.
                    shreg_d   = op[1] ? w_mag_a : w_mag_b;
                    opnd_d    = op[1] ? w_mag_b : w_mag_a;
                    acc_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end else begin
                    if (mthi) hi_d = busA;
                    if (mtlo) lo_d = busA;
                end
            end
            RUN: begin
                acc_d   = w_acc_nxt;
                shreg_d = {shreg_q[WIDTH-2:0], w_qbit};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MDU_ITERS - 1))
                    state_d = FIXUP;
            end
            FIXUP: begin
                if (op_q[1]) begin
                    hi_d = w_rem;
                    lo_d = w_quot;
                end else begin
                    hi_d = w_prod[2*WIDTH-1:WIDTH];
                    lo_d = w_prod[WIDTH-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= MDU_MULT;
            neg_a_q   <= 1'b0;
            neg_res_q <= 1'b0;
            opnd_q    <= '0;
            shreg_q   <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_a_q   <= neg_a_d;
            neg_res_q <= neg_res_d;
            opnd_q    <= opnd_d;
            shreg_q   <= shreg_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Scoreboard bench for mult_div_unit with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        mthi;
    logic        mtlo;
    logic [31:0] busA;
    logic [31:0] busB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb[$];

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busA  (busA),
        .busB  (busB),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, expected no done", hi, lo);
            end else begin
                check("result", {hi, lo}, sb.pop_front());
            end
        end
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit now, input bit with_mthi);
        if (!now) @(negedge clk);
        start = 1'b1;
        op    = o;
        busA  = a;
        busB  = b;
        mthi  = with_mthi;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        mthi  = 1'b0;
        busA  = $urandom;
        busB  = $urandom;
    endtask

    task automatic wait_done(input int inject);
        int          cyc;
        bit          seen;
        logic [63:0] snap;
        cyc  = 0;
        seen = 1'b0;
        snap = '0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) cyc++;
            if (cyc == inject) begin
                snap  = {hi, lo};
                start = 1'b1;
                op    = 2'b10;
                mtlo  = 1'b1;
                busA  = 32'hDEAD_BEEF;
                busB  = 32'h0000_0001;
            end else if (inject >= 0 && cyc == inject + 1) begin
                start = 1'b0;
                mtlo  = 1'b0;
                check("ignored_while_busy", {hi, lo}, snap);
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done within 50 cycles, expected done");
        end else begin
            check("busy_cycles", 64'(cyc), 64'd33);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        busA  = '0;
        busB  = '0;
        #12;
        check("reset_hilo", {hi, lo}, 64'h0);
        check("reset_busy_done", {62'h0, busy, done}, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Idle register moves
        @(negedge clk);
        mthi = 1'b1;
        busA = 32'h0000_1234;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi", {hi, lo}, {32'h0000_1234, 32'h0});
        mthi = 1'b1;
        mtlo = 1'b1;
        busA = 32'h55AA_00FF;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthi_mtlo", {hi, lo}, {32'h55AA_00FF, 32'h55AA_00FF});

        // multu with simultaneous mthi: start wins
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1);
        wait_done(-1);
        // Back-to-back starts issued in the done cycle
        launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, 1'b0);
        wait_done(-1);
        launch(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 64'h0000_0000_0000_001E, 1'b1, 1'b0);
        wait_done(-1);
        launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0);
        wait_done(-1);
        launch(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b1, 1'b0);
        wait_done(-1);
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1, 1'b0);
        wait_done(-1);
        launch(2'b11, 32'h0000_0064, 32'h0000_0000, 64'h0000_0064_FFFF_FFFF, 1'b1, 1'b0);
        wait_done(-1);
        launch(2'b10, 32'hFFFF_FF9C, 32'h0000_0000, 64'hFFFF_FF9C_FFFF_FFFF, 1'b1, 1'b0);
        wait_done(-1);
        launch(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF, 1'b1, 1'b0);
        wait_done(-1);

        // multu with a start/mtlo pulse injected mid-run
        launch(2'b01, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
        wait_done(5);

        // Asynchronous reset in the middle of a divu
        launch(2'b11, 32'd1000, 32'd3, 64'h0000_0001_0000_014D, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_hilo", {hi, lo}, 64'h0);
        check("abort_busy_done", {62'h0, busy, done}, 64'h0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        launch(2'b11, 32'd1000, 32'd7, 64'h0000_0006_0000_008E, 1'b1, 1'b0);
        wait_done(-1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
